// File: rtl/axi_mst_write_burst_if.sv
// AXI4 write-only bundle (AW, W, B channels) used by axi_mst_write_burst.
interface axi_mst_write_burst_if #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 64
);
    logic [ID_WIDTH-1:0]     awid;
    logic [31:0]             awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awregion;
    logic [3:0]              awqos;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awregion, awqos, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
               awregion, awqos, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_mst_write_burst.sv
// Streams s_axis data out as NBURST AXI4 INCR write bursts of BLEN+1 beats each.
// Define AXI_MST_WRITE_BURST_ERRCNT_EN to add the saturating ERR_CNT error-response counter.
module axi_mst_write_burst #(
    parameter int ID_WIDTH   = 1,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  trigger,
    axi_mst_write_burst_if.master m_axi,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  START_REG,
    input  logic [31:0]           ADDR_REG,
    input  logic [31:0]           NBURST_REG,
    input  logic [7:0]            BLEN_REG,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
`ifdef AXI_MST_WRITE_BURST_ERRCNT_EN
    ,
    output logic [15:0]           ERR_CNT
`endif
);
    localparam int         BB_SHIFT  = $clog2(DATA_WIDTH / 8);
    localparam int         PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [3:0] OUTST_MAX = 4'(MAX_OUTST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LATCH,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Reset asserts asynchronously but releases two clocks after rstn rises.
    logic [1:0] rst_sync_reg;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync_reg <= '0;
        else       rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
    assign rst_int_n = rst_sync_reg[1];

    logic [1:0] start_sync_reg;
    logic [1:0] trig_sync_reg;
    logic       start_sync;
    logic       trig_sync;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            start_sync_reg <= '0;
            trig_sync_reg  <= '0;
        end else begin
            start_sync_reg <= {start_sync_reg[0], START_REG};
            trig_sync_reg  <= {trig_sync_reg[0], trigger};
        end
    end
    assign start_sync = start_sync_reg[1];
    assign trig_sync  = trig_sync_reg[1];

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [31:0] nburst_reg;
    logic [7:0]  blen_reg;
    logic [31:0] burst_bytes_reg;
    logic [31:0] aw_cnt_reg;
    logic [31:0] w_cnt_reg;
    logic [3:0]  outst_reg;
    logic [7:0]  beat_reg;
    logic        w_active_reg;
    logic        err_reg;

    logic awvalid_c, bready_c, busy_c, done_c, wvalid_c;
    logic aw_hs, w_hs, b_hs;
    logic fifo_empty, fifo_full, fifo_push;

    assign aw_hs = awvalid_c && m_axi.awready;
    assign w_hs  = wvalid_c && m_axi.wready;
    assign b_hs  = m_axi.bvalid && bready_c;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) state_reg <= S_IDLE;
        else            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        awvalid_c  = 1'b0;
        bready_c   = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state_reg)
            S_IDLE:  if (start_sync) state_next = S_ARM;
            S_ARM:   if (trig_sync) state_next = S_LATCH;
            S_LATCH: begin
                busy_c     = 1'b1;
                state_next = (NBURST_REG == 32'd0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy_c    = 1'b1;
                bready_c  = 1'b1;
                awvalid_c = (aw_cnt_reg < nburst_reg) && (outst_reg < OUTST_MAX);
                if (aw_cnt_reg == nburst_reg && w_cnt_reg == nburst_reg)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy_c   = 1'b1;
                bready_c = 1'b1;
                if (outst_reg == 4'd0) state_next = S_DONE;
            end
            S_DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
                if (!trig_sync && !start_sync) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            addr_reg        <= '0;
            nburst_reg      <= '0;
            blen_reg        <= '0;
            burst_bytes_reg <= '0;
            aw_cnt_reg      <= '0;
            w_cnt_reg       <= '0;
            outst_reg       <= '0;
            beat_reg        <= '0;
            w_active_reg    <= 1'b0;
            err_reg         <= 1'b0;
        end else if (state_reg == S_LATCH) begin
            addr_reg        <= ADDR_REG;
            nburst_reg      <= NBURST_REG;
            blen_reg        <= BLEN_REG;
            burst_bytes_reg <= (32'(BLEN_REG) + 32'd1) << BB_SHIFT;
            aw_cnt_reg      <= '0;
            w_cnt_reg       <= '0;
            outst_reg       <= '0;
            beat_reg        <= '0;
            w_active_reg    <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            if (aw_hs) begin
                addr_reg   <= addr_reg + burst_bytes_reg;
                aw_cnt_reg <= aw_cnt_reg + 32'd1;
            end
            if (aw_hs && !b_hs)
                outst_reg <= outst_reg + 4'd1;
            else if (b_hs && !aw_hs && outst_reg != 4'd0)
                outst_reg <= outst_reg - 4'd1;
            if (b_hs && m_axi.bresp != 2'b00)
                err_reg <= 1'b1;
            // A W burst may only open once its AW has been accepted.
            if (!w_active_reg) begin
                if (state_reg == S_RUN && w_cnt_reg < aw_cnt_reg)
                    w_active_reg <= 1'b1;
            end else if (w_hs) begin
                if (beat_reg == blen_reg) begin
                    w_active_reg <= 1'b0;
                    beat_reg     <= '0;
                    w_cnt_reg    <= w_cnt_reg + 32'd1;
                end else begin
                    beat_reg <= beat_reg + 8'd1;
                end
            end
        end
    end

    // First-word fall-through FIFO; extra pointer bit separates full from empty.
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr_reg;
    logic [PTR_W:0]        rd_ptr_reg;

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                        (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign fifo_push  = s_axis_tvalid && !fifo_full;

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= s_axis_tdata;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (w_hs)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

`ifdef AXI_MST_WRITE_BURST_ERRCNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n)
            err_cnt_reg <= '0;
        else if (state_reg == S_LATCH)
            err_cnt_reg <= '0;
        else if (b_hs && m_axi.bresp != 2'b00 && err_cnt_reg != 16'hFFFF)
            err_cnt_reg <= err_cnt_reg + 16'd1;
    end
    assign ERR_CNT = err_cnt_reg;
`endif

    assign wvalid_c      = w_active_reg && !fifo_empty;
    assign s_axis_tready = !fifo_full;

    assign m_axi.awid     = '0;
    assign m_axi.awaddr   = addr_reg;
    assign m_axi.awlen    = blen_reg;
    assign m_axi.awsize   = 3'(BB_SHIFT);
    assign m_axi.awburst  = 2'b01;
    assign m_axi.awlock   = 1'b0;
    assign m_axi.awcache  = 4'b0000;
    assign m_axi.awprot   = 3'b010;
    assign m_axi.awregion = 4'b0000;
    assign m_axi.awqos    = 4'b0000;
    assign m_axi.awvalid  = awvalid_c;
    assign m_axi.wdata    = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
    assign m_axi.wstrb    = '1;
    assign m_axi.wlast    = w_active_reg && (beat_reg == blen_reg);
    assign m_axi.wvalid   = wvalid_c;
    assign m_axi.bready   = bready_c;

    assign BUSY = busy_c;
    assign DONE = done_c;
    assign ERR  = err_reg;

    // Response IDs carry no information for a single-ID master.
    logic unused_bid;
    assign unused_bid = ^m_axi.bid;
endmodule

// File: tb/tb_axi_mst_write_burst.sv
// Directed bench for axi_mst_write_burst: AXI slave model, stream source and W scoreboard.
module tb_axi_mst_write_burst;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          trigger = 1'b0;
    logic          START_REG = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [31:0]   ADDR_REG = '0;
    logic [31:0]   NBURST_REG = '0;
    logic [7:0]    BLEN_REG = '0;
    logic          BUSY, DONE, ERR;
`ifdef AXI_MST_WRITE_BURST_ERRCNT_EN
    logic [15:0]   ERR_CNT;
`endif

    axi_mst_write_burst_if #(.ID_WIDTH(1), .DATA_WIDTH(DW)) axi_if ();

    axi_mst_write_burst #(
        .ID_WIDTH(1), .DATA_WIDTH(DW), .FIFO_DEPTH(32), .MAX_OUTST(2)
    ) dut (
        .clk(clk), .rstn(rstn), .trigger(trigger), .m_axi(axi_if),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .START_REG(START_REG),
        .ADDR_REG(ADDR_REG), .NBURST_REG(NBURST_REG), .BLEN_REG(BLEN_REG),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
`ifdef AXI_MST_WRITE_BURST_ERRCNT_EN
        , .ERR_CNT(ERR_CNT)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [DW-1:0] stream_q[$];
    logic [DW-1:0] exp_data[$];
    logic [1:0]    b_q[$];

    logic aw_rand = 1'b0, w_rand = 1'b0, s_rand = 1'b0, b_hold = 1'b0, s_en = 1'b1;
    int   err_burst = -1;
    logic [31:0] job_addr = '0;
    logic [7:0]  job_blen = '0;
    int   aw_hs_cnt = 0, w_beat_cnt = 0, w_burst_cnt = 0, beat_idx = 0, b_hs_cnt = 0;
    int   aw_seen = 0, w_seen = 0, b1_cyc = 0, aw3_cyc = 0;
    int   word_seq = 0;
    logic s_hs = 1'b0, b_hs_now = 1'b0, aw_pend = 1'b0, w_pend = 1'b0;
    logic [31:0] aw_pend_addr = '0;
    logic [31:0] exp_addr;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave / stream model: observe at negedge, drive 1 time unit after posedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            s_hs     = 1'b0;
            b_hs_now = 1'b0;
            if (rstn) begin
                if (aw_pend) begin
                    check_val("awvalid_hold", 64'(axi_if.awvalid), 64'd1);
                    check_val("awaddr_hold", 64'(axi_if.awaddr), 64'(aw_pend_addr));
                end
                if (w_pend) check_val("wvalid_hold", 64'(axi_if.wvalid), 64'd1);
                if (axi_if.awvalid) aw_seen++;
                if (axi_if.wvalid) w_seen++;

                if (axi_if.wvalid && axi_if.wready) begin
                    check_val("w_after_aw", 64'(aw_hs_cnt > w_burst_cnt), 64'd1);
                    if (exp_data.size() == 0) check_val("wdata_avail", 64'd0, 64'd1);
                    else check_val("wdata", axi_if.wdata, exp_data.pop_front());
                    check_val("wlast", 64'(axi_if.wlast), 64'(beat_idx == int'(job_blen)));
                    w_beat_cnt++;
                    if (beat_idx == int'(job_blen)) begin
                        b_q.push_back((w_burst_cnt == err_burst) ? 2'b10 : 2'b00);
                        $display("W   burst %0d complete, %0d beats so far", w_burst_cnt, w_beat_cnt);
                        w_burst_cnt++;
                        beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end

                if (axi_if.awvalid && axi_if.awready) begin
                    exp_addr = job_addr + 32'(aw_hs_cnt) * ((32'(job_blen) + 32'd1) * 32'd8);
                    check_val("awaddr", 64'(axi_if.awaddr), 64'(exp_addr));
                    check_val("awlen", 64'(axi_if.awlen), 64'(job_blen));
                    $display("AW  #%0d addr=0x%08h len=%0d cycle=%0d", aw_hs_cnt, axi_if.awaddr, axi_if.awlen, cyc);
                    aw_hs_cnt++;
                    if (aw_hs_cnt == 3) aw3_cyc = cyc;
                end

                if (axi_if.bvalid && axi_if.bready) begin
                    b_hs_now = 1'b1;
                    b_hs_cnt++;
                    if (b_hs_cnt == 1) b1_cyc = cyc;
                    $display("B   #%0d resp=%0d cycle=%0d", b_hs_cnt - 1, axi_if.bresp, cyc);
                end

                s_hs = s_axis_tvalid && s_axis_tready;
                if (s_hs) begin
                    exp_data.push_back(s_axis_tdata);
                    stream_q.delete(0);
                end
                aw_pend      = axi_if.awvalid && !axi_if.awready;
                aw_pend_addr = axi_if.awaddr;
                w_pend       = axi_if.wvalid && !axi_if.wready;
            end else begin
                aw_pend = 1'b0;
                w_pend  = 1'b0;
            end

            @(posedge clk);
            #1;
            if (rstn) begin
                axi_if.awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                axi_if.wready  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (b_hs_now) axi_if.bvalid = 1'b0;
                if (!axi_if.bvalid && b_q.size() > 0 && !b_hold) begin
                    axi_if.bresp  = b_q.pop_front();
                    axi_if.bvalid = 1'b1;
                end
                if (!s_axis_tvalid || s_hs) begin
                    s_axis_tvalid = s_en && (stream_q.size() > 0) &&
                                    (!s_rand || ($urandom_range(0, 3) != 0));
                    if (stream_q.size() > 0) s_axis_tdata = stream_q[0];
                end
            end
        end
    end

    task automatic new_job(input logic [31:0] addr, input logic [31:0] nburst,
                           input logic [7:0] blen, input int n_words);
        job_addr = addr; job_blen = blen;
        aw_hs_cnt = 0; w_beat_cnt = 0; w_burst_cnt = 0; beat_idx = 0; b_hs_cnt = 0;
        aw_seen = 0; w_seen = 0; b1_cyc = 0; aw3_cyc = 0;
        for (int i = 0; i < n_words; i++) begin
            stream_q.push_back({32'hD47A0000, 32'(word_seq)});
            word_seq++;
        end
        ADDR_REG = addr; NBURST_REG = nburst; BLEN_REG = blen;
        START_REG = 1'b1; trigger = 1'b1;
    endtask

    task automatic wait_done(input int limit, output int latency);
        int busy_at;
        busy_at = -1;
        latency = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #2;
            if (BUSY && busy_at < 0) busy_at = i;
            if (DONE) begin
                latency = i - busy_at;
                break;
            end
        end
        if (latency < 0) check_val("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic finish_job();
        START_REG = 1'b0; trigger = 1'b0;
        for (int i = 0; i < 10 && DONE; i++) begin @(posedge clk); #2; end
        check_val("done_release", 64'(DONE), 64'd0);
        check_val("busy_release", 64'(BUSY), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        axi_if.awready = 1'b0; axi_if.wready = 1'b0; axi_if.bvalid = 1'b0;
        axi_if.bresp = 2'b00; axi_if.bid = '0;

        // Reset state and constant channel fields
        #3;
        check_val("rst_outputs", 64'({axi_if.awvalid, axi_if.wvalid, axi_if.wlast,
                                      axi_if.bready, BUSY, DONE, ERR}), 64'd0);
        check_val("rst_tready", 64'(s_axis_tready), 64'd1);
        check_val("awsize", 64'(axi_if.awsize), 64'd3);
        check_val("awburst", 64'(axi_if.awburst), 64'd1);
        check_val("awprot", 64'(axi_if.awprot), 64'd2);
        check_val("wstrb", 64'(axi_if.wstrb), 64'hFF);
        check_val("aw_zero_fields", 64'({axi_if.awid, axi_if.awlock, axi_if.awcache,
                                         axi_if.awregion, axi_if.awqos}), 64'd0);
        repeat (3) @(posedge clk); #2;
        rstn = 1'b1;
        repeat (4) @(posedge clk); #2;

        // 4 bursts of 16 beats from 0x1000
        new_job(32'h1000, 32'd4, 8'd15, 64);
        wait_done(600, lat);
        check_val("t1_aw_count", 64'(aw_hs_cnt), 64'd4);
        check_val("t1_beats", 64'(w_beat_cnt), 64'd64);
        check_val("t1_wlast_count", 64'(w_burst_cnt), 64'd4);
        check_val("t1_b_count", 64'(b_hs_cnt), 64'd4);
        check_val("t1_err", 64'(ERR), 64'd0);
        check_val("t1_busy_at_done", 64'(BUSY), 64'd1);
        check_val("t1_leftover", 64'(exp_data.size() + stream_q.size()), 64'd0);
        finish_job();

        // NBURST=0: no traffic, DONE right after LATCH
        new_job(32'h5000, 32'd0, 8'd3, 0);
        wait_done(30, lat);
        check_val("t2_latency_ok", 64'(lat >= 0 && lat <= 3), 64'd1);
        check_val("t2_awvalid_seen", 64'(aw_seen), 64'd0);
        check_val("t2_wvalid_seen", 64'(w_seen), 64'd0);
        finish_job();

        // Outstanding limit of 2 with B withheld
        b_hold = 1'b1;
        new_job(32'h8000, 32'd3, 8'd1, 6);
        repeat (40) @(posedge clk); #2;
        check_val("t3_aw_at_limit", 64'(aw_hs_cnt), 64'd2);
        check_val("t3_awvalid_low", 64'(axi_if.awvalid), 64'd0);
        b_hold = 1'b0;
        wait_done(200, lat);
        check_val("t3_aw3_after_b1", 64'(aw3_cyc > b1_cyc), 64'd1);
        check_val("t3_aw_count", 64'(aw_hs_cnt), 64'd3);
        check_val("t3_b_count", 64'(b_hs_cnt), 64'd3);
        finish_job();

        // Random backpressure on AW, W and the stream
        aw_rand = 1'b1; w_rand = 1'b1; s_rand = 1'b1;
        new_job(32'h2000, 32'd8, 8'd3, 32);
        wait_done(3000, lat);
        check_val("t4_aw_count", 64'(aw_hs_cnt), 64'd8);
        check_val("t4_beats", 64'(w_beat_cnt), 64'd32);
        check_val("t4_leftover", 64'(exp_data.size() + stream_q.size()), 64'd0);
        check_val("t4_err", 64'(ERR), 64'd0);
        aw_rand = 1'b0; w_rand = 1'b0; s_rand = 1'b0;
        finish_job();

        // Second of three bursts answered with SLVERR
        err_burst = 1;
        new_job(32'h9000, 32'd3, 8'd0, 3);
        wait_done(200, lat);
        check_val("t5_err", 64'(ERR), 64'd1);
`ifdef AXI_MST_WRITE_BURST_ERRCNT_EN
        check_val("t5_err_cnt", 64'(ERR_CNT), 64'd1);
`endif
        err_burst = -1;
        finish_job();

        // Reset pulse during RUN, then a clean job
        new_job(32'h3000, 32'd4, 8'd7, 32);
        for (int i = 0; i < 100 && w_seen == 0; i++) begin @(posedge clk); #2; end
        check_val("t6_run_reached", 64'(w_seen > 0), 64'd1);
        rstn = 1'b0;
        s_en = 1'b0; s_axis_tvalid = 1'b0;
        stream_q.delete(); exp_data.delete(); b_q.delete();
        axi_if.bvalid = 1'b0;
        START_REG = 1'b0; trigger = 1'b0;
        #1;
        check_val("t6_rst_outputs", 64'({axi_if.awvalid, axi_if.wvalid, axi_if.wlast,
                                         axi_if.bready, BUSY, DONE, ERR}), 64'd0);
        repeat (3) @(posedge clk); #2;
        rstn = 1'b1;
        repeat (4) @(posedge clk); #2;
        s_en = 1'b1;
        new_job(32'h4000, 32'd2, 8'd3, 8);
        wait_done(300, lat);
        check_val("t6_aw_count", 64'(aw_hs_cnt), 64'd2);
        check_val("t6_beats", 64'(w_beat_cnt), 64'd8);
        check_val("t6_err", 64'(ERR), 64'd0);
        check_val("t6_leftover", 64'(exp_data.size() + stream_q.size()), 64'd0);
        finish_job();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
